// File: rtl/ask_pkg.sv
// Shared constants and FSM state encoding for the ASK demodulator.
package ask_pkg;

    localparam int unsigned ASK_MID        = 32767;
    localparam int unsigned ASK_BIT_CYCLES = 9766;
    localparam int unsigned ASK_CODE_BITS  = 16;
    localparam int unsigned SAMPLE_W       = 16;
    localparam int unsigned ACC_W          = 29;
    localparam int unsigned CNT_W          = 14;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ask_bit_integrator.sv
// Rectifies each ASK sample and integrates magnitude over one bit period.
module ask_bit_integrator
    import ask_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = ASK_BIT_CYCLES,
    parameter int unsigned MID        = ASK_MID
) (
    input  logic                clk_100M,
    input  logic                rst_n,
    input  logic                run,
    input  logic                restart,
    input  logic [SAMPLE_W-1:0] ask_in,
    output logic                dec_c,
    output logic [ACC_W-1:0]    sum_c
);

    localparam logic [SAMPLE_W-1:0] MID_L = SAMPLE_W'(MID);
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(BIT_CYCLES - 1);

    logic [SAMPLE_W-1:0] mag_c;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // restart makes the current sample sample 0 of a fresh bit period
    always_comb begin
        mag_c = (ask_in >= MID_L) ? (ask_in - MID_L) : (MID_L - ask_in);
        sum_c = acc_q + ACC_W'(mag_c);
        dec_c = run && !restart && (cnt_q == LAST);
        acc_d = '0;
        cnt_d = '0;
        if (restart) begin
            acc_d = ACC_W'(mag_c);
            cnt_d = CNT_W'(1);
        end else if (run && !dec_c) begin
            acc_d = sum_c;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ask_demod.sv
// ASK demodulator: energy-per-bit decisions assembled into MSB-first code words.
module ask_demod
    import ask_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = ASK_BIT_CYCLES,
    parameter int unsigned CODE_BITS  = ASK_CODE_BITS,
    parameter int unsigned MID        = ASK_MID
) (
    input  logic                 clk_100M,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [SAMPLE_W-1:0]  ask_in,
    input  logic                 frame_start,
    input  logic [ACC_W-1:0]     threshold,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [CODE_BITS-1:0] code_out,
    output logic                 code_valid,
    output logic                 busy
);

    localparam int unsigned       IDX_W   = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB = IDX_W'(CODE_BITS - 1);

    state_t               state_q, state_d;
    logic [CODE_BITS-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CODE_BITS-1:0] code_d;
    logic                 bit_out_d, bit_valid_d, code_valid_d, busy_d;
    logic                 restart_c, run_c, dec_c, bit_c;
    logic [ACC_W-1:0]     sum_c;

    assign restart_c = en && frame_start;
    assign run_c     = (state_q == RUN) && en;

    ask_bit_integrator #(
        .BIT_CYCLES (BIT_CYCLES),
        .MID        (MID)
    ) u_integrator (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .run      (run_c),
        .restart  (restart_c),
        .ask_in   (ask_in),
        .dec_c    (dec_c),
        .sum_c    (sum_c)
    );

    // Next-state, word assembly and output strobes
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        code_d       = code_out;
        bit_out_d    = bit_out;
        bit_valid_d  = 1'b0;
        code_valid_d = 1'b0;
        bit_c        = (sum_c > threshold);

        case (state_q)
            IDLE:    if (en && frame_start) state_d = RUN;
            RUN:     if (!en)               state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (restart_c || ((state_q == RUN) && !en)) begin
            shreg_d = '0;
            idx_d   = IDX_MSB;
        end else if (dec_c) begin
            bit_out_d       = bit_c;
            bit_valid_d     = 1'b1;
            shreg_d[idx_q]  = bit_c;
            if (idx_q == '0) begin
                code_d       = shreg_d;
                code_valid_d = 1'b1;
                shreg_d      = '0;
                idx_d        = IDX_MSB;
            end else begin
                idx_d = idx_q - IDX_W'(1);
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            idx_q      <= IDX_MSB;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            code_out   <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            bit_out    <= bit_out_d;
            bit_valid  <= bit_valid_d;
            code_out   <= code_d;
            code_valid <= code_valid_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ask_demod.sv
// Scoreboard bench for ask_demod with a shortened bit period.
module tb_ask_demod;

    localparam int BC = 20;
    localparam int NB = 16;

    logic        clk_100M = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] ask_in = 16'd32767;
    logic        frame_start = 1'b0;
    logic [28:0] threshold = '0;
    logic        bit_out, bit_valid, code_valid, busy;
    logic [15:0] code_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic        bq[$];
    logic [15:0] cq[$];
    int          tq[$];
    logic [15:0] last_code = '0;

    typedef struct {
        logic [15:0] code;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [28:0] thr;
        logic        fs;
    } vec_t;

    vec_t vt[8];

    ask_demod #(.BIT_CYCLES(BC), .CODE_BITS(NB), .MID(32767)) dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .en          (en),
        .ask_in      (ask_in),
        .frame_start (frame_start),
        .threshold   (threshold),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .busy        (busy)
    );

    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_100M);
        #1;
    endtask

    function automatic longint rect(input logic [15:0] s);
        longint d;
        d = longint'(s) - 64'sd32767;
        return (d < 0) ? -d : d;
    endfunction

    // Drive nbits full bit periods of code (MSB first) then `extra` filler samples.
    task automatic send(input logic [15:0] code, input int nbits, input int extra,
                        input logic [15:0] hi, input logic [15:0] lo,
                        input logic [28:0] thr, input logic fs);
        logic [15:0] word;
        logic [15:0] smp;
        logic        eb;
        int          start;
        word = '0;
        threshold = thr;
        start = cyc;
        for (int b = 0; b < nbits; b++) begin
            smp = code[15-b] ? hi : lo;
            eb = (rect(smp) * BC) > longint'(thr);
            word[15-b] = eb;
            bq.push_back(eb);
            for (int s = 0; s < BC; s++) begin
                ask_in = smp;
                frame_start = fs && (b == 0) && (s == 0);
                step();
            end
        end
        frame_start = 1'b0;
        if (nbits == NB) begin
            cq.push_back(word);
            tq.push_back(start + NB * BC);
            last_code = word;
        end
        for (int s = 0; s < extra; s++) begin
            ask_in = lo;
            step();
        end
    endtask

    task automatic drain(input string name);
        repeat (3) step();
        check({name, "_bits_left"}, 32'(bq.size()), 32'd0);
        check({name, "_codes_left"}, 32'(cq.size()), 32'd0);
    endtask

    always @(negedge clk_100M) begin
        if (bit_valid === 1'b1) begin
            if (bq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_bit_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                check("bit_out", 32'(bit_out), 32'(bq.pop_front()));
            end
        end
        if (code_valid === 1'b1) begin
            if (cq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_code_valid: got 1 expected 0, code %0h (cycle %0d)", code_out, cyc);
            end else begin
                check("code_out", 32'(code_out), 32'(cq.pop_front()));
                check("code_cycle", 32'(cyc), 32'(tq.pop_front()));
            end
        end
    end

    initial begin
        vt[0] = '{16'h0000, 16'd32767, 16'd32767, 29'd1000,   1'b1};
        vt[1] = '{16'hA5C3, 16'd48767, 16'd32767, 29'd100000, 1'b1};
        vt[2] = '{16'hA5C3, 16'd48767, 16'd32767, 29'd100000, 1'b0};
        vt[3] = '{16'hFFFF, 16'd32768, 16'd32768, 29'd20,     1'b1};
        vt[4] = '{16'hFFFF, 16'd32768, 16'd32768, 29'd19,     1'b1};
        vt[5] = '{16'h3C96, 16'd16767, 16'd32767, 29'd100000, 1'b1};
        vt[6] = '{16'h1234, 16'd65535, 16'd0,     29'd655359, 1'b0};
        vt[7] = '{16'h5A5A, 16'd65535, 16'd0,     29'd655360, 1'b1};

        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit_out", 32'(bit_out), 32'd0);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_code_out", 32'(code_out), 32'd0);
        check("rst_code_valid", 32'(code_valid), 32'd0);

        rst_n = 1'b1;
        en = 1'b1;
        repeat (4) step();
        check("idle_no_start_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            send(vt[i].code, NB, 0, vt[i].hi, vt[i].lo, vt[i].thr, vt[i].fs);
            if (i == 0) check("run_busy", 32'(busy), 32'd1);
        end
        drain("table");

        // Resync partway through bit 7
        send(16'hBEEF, 7, BC / 2, 16'd48767, 16'd32767, 29'd100000, 1'b1);
        send(16'h4C1D, NB, 0, 16'd48767, 16'd32767, 29'd100000, 1'b1);
        drain("resync");

        // Resync on the last sample of a bit period
        send(16'hF0F0, 3, BC - 1, 16'd48767, 16'd32767, 29'd100000, 1'b1);
        send(16'h0FF1, NB, 0, 16'd48767, 16'd32767, 29'd100000, 1'b1);
        drain("resync_on_decision");

        // en dropped mid-word
        send(16'hFFFF, 5, 7, 16'd48767, 16'd32767, 29'd100000, 1'b1);
        en = 1'b0;
        step();
        check("en_low_busy", 32'(busy), 32'd0);
        check("en_low_code_hold", 32'(code_out), 32'(last_code));
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        check("fs_ignored_busy", 32'(busy), 32'd0);
        en = 1'b1;
        repeat (2 * BC) step();
        check("reenable_busy", 32'(busy), 32'd0);
        drain("en_drop");

        // Asynchronous reset while running
        send(16'hAAAA, 3, 5, 16'd48767, 16'd32767, 29'd100000, 1'b1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        @(negedge clk_100M);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_bit_out", 32'(bit_out), 32'd0);
        check("arst_bit_valid", 32'(bit_valid), 32'd0);
        check("arst_code_out", 32'(code_out), 32'd0);
        check("arst_code_valid", 32'(code_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_busy", 32'(busy), 32'd0);
        drain("reset");

        send(16'hA5C3, NB, 0, 16'd48767, 16'd32767, 29'd100000, 1'b1);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
